// File: rtl/ram_dev.sv
// rtl/ram_dev.sv - on-chip RAM slave: byte/half/word data port with wait states plus registered fetch port
module ram_dev #(
    parameter int    AW          = 10,
    parameter int    WAIT_CYCLES = 0,
    parameter string INIT_FILE   = ""
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] addr_i,
    input  logic [31:0] data_i,
    input  logic [1:0]  sel_i,
    input  logic        sext_i,
    input  logic        rd_i,
    input  logic        we_i,
    output logic [31:0] data_o,
    output logic        ack_o,
    output logic        err_o,
    input  logic [31:0] inst_addr_i,
    output logic [31:0] inst_data_o
);

    localparam int         DEPTH     = 1 << AW;
    localparam logic [3:0] WAIT_INIT = 4'(WAIT_CYCLES);

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_ACK} state_t;

    logic [31:0] mem [DEPTH];

    state_t      state;
    logic [3:0]  cnt;
    logic        run;
    logic [AW+1:0] lat_addr;
    logic [31:0] lat_data;
    logic [1:0]  lat_sel;
    logic        lat_sext;
    logic        lat_we;

    logic [AW+1:0] req_addr;
    logic [31:0] req_data;
    logic [1:0]  req_sel;
    logic        req_sext;
    logic        req_we;
    logic        accept;
    logic        go_ack;
    logic        mis;
    logic [AW-1:0] word_idx;
    logic [1:0]  lane;
    logic [31:0] cur_word;
    logic [31:0] shifted;
    logic [15:0] half_v;
    logic [31:0] rd_val;
    logic [31:0] wr_val;
    logic [3:0]  wr_mask;
    logic        unused;

    assign unused = ^{addr_i[31:AW+2], inst_addr_i[31:AW+2], inst_addr_i[1:0]};

    // Holds off acceptance until the first edge after reset release, so no
    // access can start or commit while rst is low.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) run <= 1'b0;
        else      run <= 1'b1;
    end

    // The access happens on the edge entering ACK; with no wait states that
    // edge is the acceptance edge, so the live inputs are used directly.
    always_comb begin
        req_addr = lat_addr;
        req_data = lat_data;
        req_sel  = lat_sel;
        req_sext = lat_sext;
        req_we   = lat_we;
        if (state == S_IDLE) begin
            req_addr = addr_i[AW+1:0];
            req_data = data_i;
            req_sel  = sel_i;
            req_sext = sext_i;
            req_we   = we_i;
        end
    end

    assign accept = (state == S_IDLE) && run && (rd_i || we_i);
    assign go_ack = (accept && (WAIT_CYCLES == 0)) || ((state == S_WAIT) && (cnt == 4'd1));

    assign word_idx = req_addr[AW+1:2];
    assign lane     = req_addr[1:0];
    assign cur_word = mem[word_idx];
    assign shifted  = cur_word >> {lane, 3'b000};
    assign half_v   = lane[1] ? cur_word[31:16] : cur_word[15:0];

    always_comb begin
        mis     = 1'b0;
        rd_val  = cur_word;
        wr_val  = req_data;
        wr_mask = 4'b1111;
        case (req_sel)
            2'd0: begin
                rd_val  = {{24{req_sext & shifted[7]}}, shifted[7:0]};
                wr_val  = {4{req_data[7:0]}};
                wr_mask = 4'b0001 << lane;
            end
            2'd1: begin
                mis     = lane[0];
                rd_val  = {{16{req_sext & half_v[15]}}, half_v};
                wr_val  = {2{req_data[15:0]}};
                wr_mask = lane[1] ? 4'b1100 : 4'b0011;
            end
            2'd2: mis = (lane != 2'b00);
            default: mis = 1'b1;
        endcase
    end

    always_ff @(posedge clk) begin
        if (go_ack && req_we && !mis) begin
            for (int i = 0; i < 4; i++) begin
                if (wr_mask[i]) mem[word_idx][i*8 +: 8] <= wr_val[i*8 +: 8];
            end
        end
    end

    // Fetch reads before any same-edge write lands, so it sees the old word.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) inst_data_o <= 32'd0;
        else      inst_data_o <= mem[inst_addr_i[AW+1:2]];
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= S_IDLE;
            cnt      <= 4'd0;
            ack_o    <= 1'b0;
            err_o    <= 1'b0;
            data_o   <= 32'd0;
            lat_addr <= '0;
            lat_data <= 32'd0;
            lat_sel  <= 2'd0;
            lat_sext <= 1'b0;
            lat_we   <= 1'b0;
        end else begin
            ack_o <= 1'b0;
            err_o <= 1'b0;
            if (go_ack) begin
                ack_o <= 1'b1;
                err_o <= mis;
                if (mis)          data_o <= 32'd0;
                else if (!req_we) data_o <= rd_val;
            end
            case (state)
                S_IDLE: begin
                    if (accept) begin
                        lat_addr <= addr_i[AW+1:0];
                        lat_data <= data_i;
                        lat_sel  <= sel_i;
                        lat_sext <= sext_i;
                        lat_we   <= we_i;
                        cnt      <= WAIT_INIT;
                        state    <= (WAIT_CYCLES == 0) ? S_ACK : S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (cnt == 4'd1) begin
                        cnt   <= 4'd0;
                        state <= S_ACK;
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end
                S_ACK: begin
                    cnt   <= 4'd0;
                    state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule
